// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one serial binary-to-BCD converter among NREQ requesters.
// Optional converter watchdog is built when BCD_CONV_SCHED_TIMEOUT_EN is defined.
module bcd_conv_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned BW   = 10,
    parameter int unsigned DW   = BW * 28 / 93 + 1,
    parameter int unsigned TMO  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*BW-1:0]     bin_flat,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ*DW*4-1:0]   bcd_flat,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   conv_go,
    output logic [BW-1:0]          conv_bin,
    input  logic [DW*4-1:0]        conv_bcd,
    input  logic                   conv_done,
    output logic                   err
);

    localparam int unsigned RW = DW * 4;
    localparam logic [NREQ-1:0] One = NREQ'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;

    if (NREQ < 2 || NREQ > 8 || TMO < 1 || TMO > 256) begin : g_param_err
        $error("bcd_conv_sched: parameter out of range");
    end

    state_e              state_q;
    logic [NREQ-1:0]     pending_q, pending_d;
    logic [NREQ*BW-1:0]  op_q, op_d;
    logic [2:0]          grant_q;
    logic [BW-1:0]       bin_q;
    logic [NREQ*RW-1:0]  bcd_q;
    logic [NREQ-1:0]     ack_q;
    logic                go_q;
    logic                sel_valid;
    logic [2:0]          sel_idx;

`ifdef BCD_CONV_SCHED_TIMEOUT_EN
    logic [7:0]          cnt_q;
    logic                err_q;
`endif

    // Scan from grant+NREQ down to grant+1 so the nearest channel after the last grant wins.
    always_comb begin
        int unsigned c;
        c         = 0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            c = (32'(grant_q) + k) % NREQ;
            if (|(pending_q & (One << c))) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(c);
            end
        end
    end

    // A request arriving on the channel being granted re-arms it: set beats clear.
    always_comb begin
        pending_d = pending_q;
        op_d      = op_q;
        if (state_q == StIdle && sel_valid) begin
            pending_d = pending_d & ~(One << sel_idx);
        end
        pending_d = pending_d | req;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                op_d[i*BW +: BW] = bin_flat[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= '0;
            op_q      <= '0;
            grant_q   <= 3'(NREQ - 1);
            bin_q     <= '0;
            bcd_q     <= '0;
            ack_q     <= '0;
            go_q      <= 1'b0;
`ifdef BCD_CONV_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            pending_q <= pending_d;
            op_q      <= op_d;
            ack_q     <= '0;
            go_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sel_valid) begin
                        bin_q   <= op_q[32'(sel_idx)*BW +: BW];
                        grant_q <= sel_idx;
                        go_q    <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
`ifdef BCD_CONV_SCHED_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StWait: begin
                    if (conv_done) begin
                        bcd_q[32'(grant_q)*RW +: RW] <= conv_bcd;
                        ack_q   <= One << grant_q;
                        state_q <= StStore;
                    end
`ifdef BCD_CONV_SCHED_TIMEOUT_EN
                    else if (cnt_q == 8'(TMO - 1)) begin
                        // Abandon the conversion: no ack, slot untouched, channel not re-queued.
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                StStore: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack      = ack_q;
    assign bcd_flat = bcd_q;
    assign busy     = (state_q != StIdle);
    assign grant_id = grant_q;
    assign conv_go  = go_q;
    assign conv_bin = bin_q;

`ifdef BCD_CONV_SCHED_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
